rob_retire_gen_module: RTL and testbench

//  Retire-side counterpart of dispatch ID generation. Tracks per-ROB-entry valid/complete/exception/ld/st

---
 rtl/rob_retire_gen_pkg.sv | 34 +++
 rtl/rob_retire_gen_module_sel.sv | 33 +++
 rtl/rob_retire_gen_module.sv | 209 ++++++++++++++++++++
 tb/tb_rob_retire_gen_module.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_retire_gen_pkg.sv
// Shared ROB retire definitions: pointer widths, retire FSM encoding and the
// wrap-bit age compare also used by the dispatch ID generator.
package rob_retire_gen_pkg;

  localparam int ROB_ID_WIDTH  = 8;
  localparam int ROB_IDX_WIDTH = ROB_ID_WIDTH - 1;
  localparam int ROB_DEPTH     = 2 ** ROB_IDX_WIDTH;
  localparam int RET_WIDTH     = 4;
  localparam int DSP_WIDTH     = 4;
  localparam int CMPL_PORTS    = 4;

  typedef logic [ROB_ID_WIDTH-1:0]  rob_id_t;
  typedef logic [ROB_IDX_WIDTH-1:0] rob_idx_t;

  typedef enum logic {
    RET_RUN  = 1'b0,
    RET_EXCP = 1'b1
  } ret_state_e;

  // a is older than b; IDs carry {wrap, index}
  function automatic logic func_rob_old(input rob_id_t a, input rob_id_t b);
    logic older;
    if (a[ROB_ID_WIDTH-1] != b[ROB_ID_WIDTH-1])
      older = (a[ROB_IDX_WIDTH-1:0] >= b[ROB_IDX_WIDTH-1:0]);
    else
      older = (a[ROB_IDX_WIDTH-1:0] < b[ROB_IDX_WIDTH-1:0]);
    return older;
  endfunction

  function automatic logic [2:0] func_popcnt4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/rob_retire_gen_module_sel.sv
// In-order retire selector over the 4-entry head window: a lane retires only when
// it and every older lane are ready, with at most one store per cycle.
module rob_ret_sel_module
  import rob_retire_gen_pkg::*;
(
  input  logic [RET_WIDTH-1:0] win_vld,
  input  logic [RET_WIDTH-1:0] win_cmpl,
  input  logic [RET_WIDTH-1:0] win_excp,
  input  logic [RET_WIDTH-1:0] win_st,
  input  logic                 stall,
  output logic [RET_WIDTH-1:0] ret_vld,
  output logic [RET_WIDTH-1:0] ret_st_vld
);

  logic [RET_WIDTH-1:0] lane_ok;
  logic                 chain;
  logic                 st_seen;

  always_comb begin
    lane_ok    = win_vld & win_cmpl & ~win_excp;
    ret_vld    = '0;
    chain      = ~stall;
    st_seen    = 1'b0;
    for (int k = 0; k < RET_WIDTH; k++) begin
      // a second store ends the group; later lanes wait for next cycle
      chain      = chain & lane_ok[k] & ~(win_st[k] & st_seen);
      ret_vld[k] = chain;
      st_seen    = st_seen | win_st[k];
    end
    ret_st_vld = ret_vld & win_st;
  end

endmodule

// File: rtl/rob_retire_gen_module.sv
// ROB retire tracker: per-entry valid/complete/exception/ld/st state, up to 4
// in-order retirements per cycle, flush handling and head-exception request.
//
// state    | meaning
// RET_RUN  | normal retirement from the head window
// RET_EXCP | head entry completed with exception; retire blocked until trap flush
module rob_retire_gen_module
  import rob_retire_gen_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DSP_WIDTH-1:0]             i_dsp_vld,
  input  logic [DSP_WIDTH-1:0]             i_dsp_ld_vld,
  input  logic [DSP_WIDTH-1:0]             i_dsp_st_vld,
  input  logic [ROB_ID_WIDTH-1:0]          i_dsp_rob_id,
  input  logic [CMPL_PORTS-1:0]            i_exu_cmpl_vld,
  input  logic [CMPL_PORTS*ROB_ID_WIDTH-1:0] i_exu_cmpl_rob_id,
  input  logic [CMPL_PORTS-1:0]            i_exu_cmpl_excp,
  input  logic                             i_exu_mis_ls_flush,
  input  logic [ROB_ID_WIDTH-1:0]          i_exu_mis_ls_rob_id,
  input  logic                             i_csr_trap_flush,
  input  logic                             i_rob_ret_stall,
  output logic [RET_WIDTH-1:0]             o_rob_ret_vld,
  output logic [RET_WIDTH-1:0]             o_rob_ret_ld_vld,
  output logic [RET_WIDTH-1:0]             o_rob_ret_st_vld,
  output logic [ROB_ID_WIDTH-1:0]          o_rob_ret_id,
  output logic                             o_rob_excp_req,
  output logic [ROB_ID_WIDTH-1:0]          o_rob_excp_rob_id,
  output logic                             o_rob_empty,
  output logic                             o_rob_full
);

  rob_id_t              head_q, tail_q, head_n, tail_n;
  ret_state_e           state_q, state_n;
  logic [ROB_DEPTH-1:0] valid_q, cmpl_q, excp_q, ld_q, st_q;
  logic [ROB_DEPTH-1:0] valid_n, cmpl_n, excp_n, ld_n, st_n;
  logic [ROB_DEPTH-1:0] younger;

  rob_idx_t             head_idx;
  rob_idx_t             win_idx  [RET_WIDTH];
  rob_idx_t             dsp_idx  [DSP_WIDTH];
  rob_idx_t             cmpl_idx [CMPL_PORTS];
  logic [CMPL_PORTS-1:0] cmpl_wrap_unused;

  logic [RET_WIDTH-1:0] win_vld, win_cmpl, win_excp, win_ld, win_st;
  logic [RET_WIDTH-1:0] ret_vld, ret_st_vld;
  logic                 ret_block;
  logic                 head_excp;
  logic                 dsp_en;
  logic [2:0]           ret_cnt, dsp_cnt;
  logic [ROB_ID_WIDTH:0] free_cnt;

  assign head_idx = head_q[ROB_IDX_WIDTH-1:0];

  for (genvar k = 0; k < RET_WIDTH; k++) begin : g_win
    assign win_idx[k]  = head_idx + rob_idx_t'(k);
    assign win_vld[k]  = valid_q[win_idx[k]];
    assign win_cmpl[k] = cmpl_q[win_idx[k]];
    assign win_excp[k] = excp_q[win_idx[k]];
    assign win_ld[k]   = ld_q[win_idx[k]];
    assign win_st[k]   = st_q[win_idx[k]];
  end

  for (genvar k = 0; k < DSP_WIDTH; k++) begin : g_dsp
    assign dsp_idx[k] = i_dsp_rob_id[ROB_IDX_WIDTH-1:0] + rob_idx_t'(k);
  end

  // completions address entries by index; the wrap bit is not needed for lookup
  for (genvar p = 0; p < CMPL_PORTS; p++) begin : g_cmpl
    assign cmpl_idx[p]         = i_exu_cmpl_rob_id[p*ROB_ID_WIDTH +: ROB_IDX_WIDTH];
    assign cmpl_wrap_unused[p] = i_exu_cmpl_rob_id[p*ROB_ID_WIDTH + ROB_IDX_WIDTH];
  end

  // reconstruct each slot's full ID relative to head so the age compare sees the wrap bit
  for (genvar i = 0; i < ROB_DEPTH; i++) begin : g_age
    logic slot_wrap;
    assign slot_wrap  = (rob_idx_t'(i) >= head_idx) ? head_q[ROB_ID_WIDTH-1]
                                                    : ~head_q[ROB_ID_WIDTH-1];
    assign younger[i] = func_rob_old(i_exu_mis_ls_rob_id, {slot_wrap, rob_idx_t'(i)});
  end

  assign ret_block = i_rob_ret_stall | (state_q != RET_RUN);
  assign head_excp = win_vld[0] & win_cmpl[0] & win_excp[0];

  rob_ret_sel_module u_sel (
    .win_vld    (win_vld),
    .win_cmpl   (win_cmpl),
    .win_excp   (win_excp),
    .win_st     (win_st),
    .stall      (ret_block),
    .ret_vld    (ret_vld),
    .ret_st_vld (ret_st_vld)
  );

  assign ret_cnt  = func_popcnt4(ret_vld);
  assign dsp_cnt  = func_popcnt4(i_dsp_vld);
  assign dsp_en   = ~i_csr_trap_flush & ~i_exu_mis_ls_flush;
  assign free_cnt = (ROB_ID_WIDTH+1)'(ROB_DEPTH) - (ROB_ID_WIDTH+1)'(rob_id_t'(tail_q - head_q));

  assign head_n = head_q + rob_id_t'(ret_cnt);

  always_comb begin
    tail_n = tail_q;
    if (i_csr_trap_flush)
      tail_n = head_n;
    else if (i_exu_mis_ls_flush)
      tail_n = i_exu_mis_ls_rob_id + rob_id_t'(1);
    else
      tail_n = tail_q + rob_id_t'(dsp_cnt);
  end

  always_comb begin
    state_n = state_q;
    if (i_csr_trap_flush)
      state_n = RET_RUN;
    else if ((state_q == RET_RUN) && head_excp)
      state_n = RET_EXCP;
  end

  // lowest priority first; later updates override earlier ones for the same entry
  always_comb begin
    valid_n = valid_q;
    cmpl_n  = cmpl_q;
    excp_n  = excp_q;
    ld_n    = ld_q;
    st_n    = st_q;
    for (int p = 0; p < CMPL_PORTS; p++) begin
      if (i_exu_cmpl_vld[p] && valid_q[cmpl_idx[p]]) begin
        cmpl_n[cmpl_idx[p]] = 1'b1;
        excp_n[cmpl_idx[p]] = excp_n[cmpl_idx[p]] | i_exu_cmpl_excp[p];
      end
    end
    if (dsp_en) begin
      for (int k = 0; k < DSP_WIDTH; k++) begin
        if (i_dsp_vld[k]) begin
          valid_n[dsp_idx[k]] = 1'b1;
          cmpl_n[dsp_idx[k]]  = 1'b0;
          excp_n[dsp_idx[k]]  = 1'b0;
          ld_n[dsp_idx[k]]    = i_dsp_ld_vld[k];
          st_n[dsp_idx[k]]    = i_dsp_st_vld[k];
        end
      end
    end
    for (int k = 0; k < RET_WIDTH; k++) begin
      if (ret_vld[k]) begin
        valid_n[win_idx[k]] = 1'b0;
        cmpl_n[win_idx[k]]  = 1'b0;
        excp_n[win_idx[k]]  = 1'b0;
        ld_n[win_idx[k]]    = 1'b0;
        st_n[win_idx[k]]    = 1'b0;
      end
    end
    if (i_exu_mis_ls_flush) begin
      valid_n = valid_n & ~younger;
      cmpl_n  = cmpl_n & ~younger;
      excp_n  = excp_n & ~younger;
      ld_n    = ld_n & ~younger;
      st_n    = st_n & ~younger;
    end
    if (i_csr_trap_flush) begin
      valid_n = '0;
      cmpl_n  = '0;
      excp_n  = '0;
      ld_n    = '0;
      st_n    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      state_q <= RET_RUN;
      valid_q <= '0;
      cmpl_q  <= '0;
      excp_q  <= '0;
      ld_q    <= '0;
      st_q    <= '0;
    end else begin
      head_q  <= head_n;
      tail_q  <= tail_n;
      state_q <= state_n;
      valid_q <= valid_n;
      cmpl_q  <= cmpl_n;
      excp_q  <= excp_n;
      ld_q    <= ld_n;
      st_q    <= st_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && dsp_en && (|i_dsp_vld)) begin
      assert (4'(i_dsp_vld & 4'(i_dsp_vld + 4'd1)) == 4'd0);
      assert (i_dsp_rob_id == tail_q);
      assert ((ROB_ID_WIDTH+1)'(dsp_cnt) <= free_cnt);
    end
  end

  assign o_rob_ret_vld     = ret_vld;
  assign o_rob_ret_ld_vld  = ret_vld & win_ld;
  assign o_rob_ret_st_vld  = ret_st_vld;
  assign o_rob_ret_id      = head_q;
  assign o_rob_excp_req    = (state_q == RET_EXCP);
  assign o_rob_excp_rob_id = o_rob_excp_req ? head_q : '0;
  assign o_rob_empty       = (head_q == tail_q);
  assign o_rob_full        = (head_idx == tail_q[ROB_IDX_WIDTH-1:0]) &&
                             (head_q[ROB_ID_WIDTH-1] != tail_q[ROB_ID_WIDTH-1]);

endmodule

// File: tb/tb_rob_retire_gen_module.sv
// Bench for rob_retire_gen_module: directed scenarios plus randomized traffic
// checked against a queue-based ROB model.
module tb_rob_retire_gen_module;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  dsp_vld, dsp_ld, dsp_st;
  logic [7:0]  dsp_id;
  logic [3:0]  cmpl_vld, cmpl_excp;
  logic [31:0] cmpl_id;
  logic        mis;
  logic [7:0]  mis_id;
  logic        trap, stall;
  logic [3:0]  ret_vld, ret_ld, ret_st;
  logic [7:0]  ret_id, excp_id;
  logic        excp_req, empty, full;

  always #5 clk = ~clk;

  rob_retire_gen_module dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_dsp_vld           (dsp_vld),
    .i_dsp_ld_vld        (dsp_ld),
    .i_dsp_st_vld        (dsp_st),
    .i_dsp_rob_id        (dsp_id),
    .i_exu_cmpl_vld      (cmpl_vld),
    .i_exu_cmpl_rob_id   (cmpl_id),
    .i_exu_cmpl_excp     (cmpl_excp),
    .i_exu_mis_ls_flush  (mis),
    .i_exu_mis_ls_rob_id (mis_id),
    .i_csr_trap_flush    (trap),
    .i_rob_ret_stall     (stall),
    .o_rob_ret_vld       (ret_vld),
    .o_rob_ret_ld_vld    (ret_ld),
    .o_rob_ret_st_vld    (ret_st),
    .o_rob_ret_id        (ret_id),
    .o_rob_excp_req      (excp_req),
    .o_rob_excp_rob_id   (excp_id),
    .o_rob_empty         (empty),
    .o_rob_full          (full)
  );

  typedef struct {
    logic [7:0] id;
    bit         cmpl;
    bit         excp;
    bit         ld;
    bit         st;
  } ent_t;

  ent_t       q[$];
  logic [7:0] m_head;
  bit         m_excp;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clr_in();
    dsp_vld = '0; dsp_ld = '0; dsp_st = '0; dsp_id = '0;
    cmpl_vld = '0; cmpl_excp = '0; cmpl_id = '0;
    mis = 1'b0; mis_id = '0; trap = 1'b0; stall = 1'b0;
  endtask

  task automatic set_dsp(input int n, input logic [3:0] ldm, input logic [3:0] stm);
    dsp_vld = 4'((1 << n) - 1);
    dsp_ld  = ldm & dsp_vld;
    dsp_st  = stm & dsp_vld;
    dsp_id  = m_head + 8'(q.size());
  endtask

  task automatic set_cmpl(input int p, input logic [7:0] id, input logic ex);
    cmpl_vld[p]        = 1'b1;
    cmpl_id[p*8 +: 8]  = id;
    cmpl_excp[p]       = ex;
  endtask

  // oldest-first walk of the model queue: stop at the first not-ready entry or second store
  function automatic void model_ret(input bit stl, output logic [3:0] rv,
                                    output logic [3:0] rl, output logic [3:0] rs);
    bit seen;
    seen = 0; rv = '0; rl = '0; rs = '0;
    if (!m_excp && !stl) begin
      for (int k = 0; k < 4 && k < q.size(); k++) begin
        if (!q[k].cmpl || q[k].excp || (q[k].st && seen)) break;
        rv[k] = 1'b1;
        rl[k] = q[k].ld;
        rs[k] = q[k].st;
        seen  = seen | q[k].st;
      end
    end
  endfunction

  task automatic step();
    logic [3:0] rv, rl, rs;
    int         n, pos;
    bit         head_excp;
    ent_t       e;
    @(negedge clk);
    model_ret(stall, rv, rl, rs);
    check_val("ret_vld", ret_vld, rv);
    check_val("ret_ld", ret_ld, rl);
    check_val("ret_st", ret_st, rs);
    check_val("ret_id", ret_id, m_head);
    check_val("excp_req", excp_req, m_excp);
    check_val("excp_id", excp_id, m_excp ? m_head : 8'h00);
    check_val("empty", empty, q.size() == 0);
    check_val("full", full, q.size() == 128);
    head_excp = (q.size() > 0) && q[0].cmpl && q[0].excp;
    n = 0;
    for (int k = 0; k < 4; k++) n += rv[k];
    for (int k = 0; k < n; k++) void'(q.pop_front());
    m_head = m_head + 8'(n);
    if (trap) begin
      q.delete();
      m_excp = 0;
    end else begin
      if (head_excp) m_excp = 1;
      if (mis) begin
        pos = -1;
        for (int i = 0; i < q.size(); i++) if (q[i].id == mis_id) pos = i;
        if (pos >= 0) while (q.size() > pos + 1) void'(q.pop_back());
      end
      for (int p = 0; p < 4; p++) begin
        if (cmpl_vld[p]) begin
          for (int i = 0; i < q.size(); i++) begin
            if (q[i].id[6:0] == cmpl_id[p*8 +: 7]) begin
              e = q[i];
              e.cmpl = 1;
              e.excp = e.excp | cmpl_excp[p];
              q[i] = e;
            end
          end
        end
      end
      if (!mis) begin
        for (int k = 0; k < 4; k++) begin
          if (dsp_vld[k]) begin
            e.id = dsp_id + 8'(k); e.cmpl = 0; e.excp = 0;
            e.ld = dsp_ld[k]; e.st = dsp_st[k];
            q.push_back(e);
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic advance_to(input logic [7:0] target);
    int         n;
    logic [7:0] base;
    while (m_head != target) begin
      n = (8'(target - m_head) >= 8'd4) ? 4 : int'(8'(target - m_head));
      base = m_head;
      clr_in(); set_dsp(n, 4'h0, 4'h0); step();
      clr_in(); for (int p = 0; p < n; p++) set_cmpl(p, base + 8'(p), 1'b0); step();
      clr_in(); step();
    end
  endtask

  initial begin
    logic [3:0] rv, rl, rs;
    logic [7:0] h;
    logic [3:0] ldm, stm;
    int nret, port, n, pct, r;

    m_head = '0; m_excp = 0;
    clr_in();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ret_vld", ret_vld, 4'h0);
    check_val("rst_empty", empty, 1'b1);
    check_val("rst_full", full, 1'b0);
    check_val("rst_ret_id", ret_id, 8'h00);
    check_val("rst_excp_req", excp_req, 1'b0);
    rst = 1'b0;

    // 4 ALU ops complete together and retire in one cycle
    clr_in(); set_dsp(4, 4'h0, 4'h0); step();
    clr_in(); for (int p = 0; p < 4; p++) set_cmpl(p, 8'(p), 1'b0); step();
    check_val("t1_ret", ret_vld, 4'hF);
    clr_in(); step();
    check_val("t1_head", ret_id, 8'h04);
    check_val("t1_empty", empty, 1'b1);

    // head incomplete blocks the whole group
    clr_in(); set_dsp(4, 4'h0, 4'h0); step();
    clr_in(); for (int p = 1; p < 4; p++) set_cmpl(p, 8'(4 + p), 1'b0); step();
    check_val("t2_blocked", ret_vld, 4'h0);
    clr_in(); set_cmpl(0, 8'h04, 1'b0); step();
    check_val("t2_ret", ret_vld, 4'hF);
    clr_in(); step();
    check_val("t2_head", ret_id, 8'h08);

    // {st,alu,st,ld}: one store per cycle
    clr_in(); set_dsp(4, 4'b1000, 4'b0101); step();
    clr_in(); for (int p = 0; p < 4; p++) set_cmpl(p, 8'(8 + p), 1'b0); step();
    check_val("t3_c1_ret", ret_vld, 4'b0011);
    check_val("t3_c1_st", ret_st, 4'b0001);
    clr_in(); step();
    check_val("t3_c2_ret", ret_vld, 4'b0011);
    check_val("t3_c2_st", ret_st, 4'b0001);
    check_val("t3_c2_ld", ret_ld, 4'b0010);
    clr_in(); step();
    check_val("t3_empty", empty, 1'b1);

    // fill to 128 entries, then trap-flush back to empty
    for (int c = 0; c < 32; c++) begin clr_in(); set_dsp(4, 4'h0, 4'h0); step(); end
    check_val("full_set", full, 1'b1);
    check_val("full_not_empty", empty, 1'b0);
    clr_in(); trap = 1'b1; step();
    check_val("full_trap_empty", empty, 1'b1);
    check_val("full_trap_full", full, 1'b0);

    // wrap crossing: 7E,7F,80,81 retire together
    advance_to(8'h7E);
    clr_in(); set_dsp(4, 4'h0, 4'h0); step();
    clr_in(); for (int p = 0; p < 4; p++) set_cmpl(p, 8'h7E + 8'(p), 1'b0); step();
    check_val("t4_ret", ret_vld, 4'hF);
    clr_in(); step();
    check_val("t4_head", ret_id, 8'h82);

    // head exception holds retirement until trap flush
    clr_in(); set_dsp(2, 4'h0, 4'h0); step();
    clr_in(); set_cmpl(0, 8'h82, 1'b1); set_cmpl(1, 8'h83, 1'b0); step();
    check_val("t5_pre_req", excp_req, 1'b0);
    check_val("t5_pre_ret", ret_vld, 4'h0);
    for (int c = 0; c < 3; c++) begin
      clr_in(); step();
      check_val("t5_req", excp_req, 1'b1);
      check_val("t5_id", excp_id, 8'h82);
      check_val("t5_ret", ret_vld, 4'h0);
    end
    clr_in(); trap = 1'b1; step();
    check_val("t5_empty", empty, 1'b1);
    check_val("t5_req_clr", excp_req, 1'b0);

    // mis flush at h+4 with same-cycle dispatch dropped
    h = m_head;
    clr_in(); set_dsp(4, 4'h0, 4'h0); step();
    clr_in(); set_dsp(4, 4'h0, 4'h0); step();
    clr_in(); set_dsp(3, 4'h0, 4'h0); step();
    clr_in(); set_dsp(4, 4'h0, 4'h0); mis = 1'b1; mis_id = h + 8'd4; step();
    clr_in(); set_dsp(1, 4'h0, 4'h0);
    check_val("t6_tail", dsp_id, h + 8'd5);
    for (int p = 0; p < 4; p++) set_cmpl(p, h + 8'(p), 1'b0);
    step();
    check_val("t6_ret_a", ret_vld, 4'hF);
    clr_in(); set_cmpl(0, h + 8'd4, 1'b0); set_cmpl(1, h + 8'd5, 1'b0); step();
    check_val("t6_ret_b", ret_vld, 4'b0011);
    clr_in(); step();
    check_val("t6_empty", empty, 1'b1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      clr_in();
      pct = (c < 1500) ? 25 : 70;
      stall = ($urandom_range(7) == 0);
      model_ret(stall, rv, rl, rs);
      nret = int'(rv[0]) + int'(rv[1]) + int'(rv[2]) + int'(rv[3]);
      trap = m_excp ? ($urandom_range(3) == 0) : ($urandom_range(99) == 0);
      if (!trap && q.size() > nret && $urandom_range(19) == 0) begin
        mis = 1'b1;
        mis_id = q[$urandom_range(q.size() - 1, nret)].id;
      end
      port = 0;
      for (int i = 0; i < q.size(); i++) begin
        if (!q[i].cmpl && port < 4 && $urandom_range(99) < pct) begin
          set_cmpl(port, q[i].id, $urandom_range(31) == 0);
          port++;
        end
      end
      n = $urandom_range(4);
      if (n > 128 - q.size()) n = 128 - q.size();
      ldm = '0; stm = '0;
      for (int k = 0; k < 4; k++) begin
        r = $urandom_range(2);
        ldm[k] = (r == 1);
        stm[k] = (r == 2);
      end
      set_dsp(n, ldm, stm);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
